// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: receive side of an 8N1 UART.
// Synchronises the raw rx pin, finds the start bit, samples each bit at its
// midpoint, rejects short low glitches, reports framing errors and overruns,
// and hands finished bytes to the consumer through a one-deep valid/ready
// holding register.
module uart_rx_deframer #(
    parameter int unsigned BAUDRATE     = 115200,
    parameter int unsigned CLOCK_FREQ   = 27000000,
    parameter int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUDRATE,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    // Mid-bit sampling needs at least a few clocks per bit to be meaningful.
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_rx_deframer: CLKS_PER_BIT must be at least 4");
    end

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    // Terminal counts: counter runs 0..N-1, so the sample lands on the Nth clock.
    localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    // Two-flop synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Deframing FSM
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic            done_q;
    logic            frame_err_q;
    logic            busy_q;

    // Bit timing, sampling and frame validation; done_q/frame_err_q are
    // single-cycle pulses raised on the stop-bit sample.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        if (!rxs_q) begin
                            state_q <= StData;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs_q;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            // Byte is discarded; wait out the low line.
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StBreak: begin
                    // Only one frame_err per low period, however long it lasts.
                    if (rxs_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-deep holding register
    // ------------------------------------------------------------------
    logic [7:0] rx_data_q;
    logic [7:0] rx_data_d;
    logic       rx_valid_q;
    logic       rx_valid_d;
    logic       overrun_q;
    logic       overrun_d;

    // Drain on valid&&ready; a completion either refills (slot free or being
    // drained this cycle) or is dropped with an overrun pulse.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    // Holding register state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
